ps2_device_tx: RTL

PS/2 device-side transmitter (keyboard emulator). It accepts scan-code bytes through a write port, buffers them in a small FIFO, and serializes each byte as an 11-bit PS/2 frame. The block generates both `ps2_clk` and `ps2_data`, so its outputs connect directly to the PS/2 receiver's inputs. It is used for on-chip loopback and for simulation stimulus.

---
 rtl/ps2_device_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: buffers scan-code bytes in a small FIFO and serialises each one
// as an 11-bit PS/2 frame, generating both ps2_clk and ps2_data from registers.
module ps2_device_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       inhibit,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(2 * CLK_DIV);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_BIT  = 4'd10;
    localparam logic [3:0]    ABORT_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            low_q, low_d;
    logic [10:0]     shreg_q, shreg_d;
    logic [7:0]      hold_q, hold_d;
    logic            retry_q, retry_d;
    logic            clk_q, clk_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   count_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    logic            empty;
    logic            wr_accept;
    logic            pop;
    logic [7:0]      head;

    // Frame bit i sits at position i; ps2_data is always shreg_q[0].
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign empty     = (wptr_q == rptr_q);
    assign wr_accept = wr_en && !full_q;
    assign pop       = (state_q == StIdle) && !empty && !inhibit;
    assign head      = mem[rptr_q[AW-1:0]];

    // FIFO pointers, registered full flag and sticky overflow
    always_comb begin
        wptr_d  = wr_accept ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        count_d = wptr_d - rptr_d;
        full_d  = (count_d == DEPTH_P);
        ovf_d   = ovf_q || (wr_en && full_q);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        low_d   = low_q;
        shreg_d = shreg_q;
        hold_d  = hold_q;
        retry_d = retry_q;
        clk_d   = clk_q;

        unique case (state_q)
            StIdle: begin
                clk_d   = 1'b1;
                shreg_d = '1;
                if (pop) begin
                    hold_d  = head;
                    shreg_d = make_frame(head);
                    cnt_d   = '0;
                    bit_d   = '0;
                    low_d   = 1'b0;
                    state_d = StShift;
                end
            end

            StShift: begin
                if (inhibit && (bit_q <= ABORT_MAX)) begin
                    // Host abort: release both lines and retry the held byte after the gap.
                    clk_d   = 1'b1;
                    shreg_d = '1;
                    retry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        low_d = 1'b1;
                        clk_d = 1'b0;
                    end else if (bit_q == LAST_BIT) begin
                        clk_d   = 1'b1;
                        shreg_d = '1;
                        state_d = StGap;
                    end else begin
                        low_d   = 1'b0;
                        clk_d   = 1'b1;
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {1'b1, shreg_q[10:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            StGap: begin
                clk_d   = 1'b1;
                shreg_d = '1;
                if (inhibit) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (retry_q) begin
                        retry_d = 1'b0;
                        shreg_d = make_frame(hold_q);
                        bit_d   = '0;
                        low_d   = 1'b0;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                clk_d   = 1'b1;
                shreg_d = '1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            low_q   <= 1'b0;
            shreg_q <= '1;
            hold_q  <= '0;
            retry_q <= 1'b0;
            clk_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            low_q   <= low_d;
            shreg_q <= shreg_d;
            hold_q  <= hold_d;
            retry_q <= retry_d;
            clk_q   <= clk_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ps2_clk  = clk_q;
    assign ps2_data = shreg_q[0];
    assign full     = full_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != StIdle) || !empty;

endmodule
